// File: rtl/spi_master_core.sv
// SPI master engine: one {~write, addr, data} register frame per request, any CPOL/CPHA, N active-low selects.
// Optional odd parity bit appended to the frame when SPI_PARITY_EN is defined.
module spi_master_core #(
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int SLAVES  = 1,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [$clog2(SLAVES):0]   req_slave,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic                      abort,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [SLAVES-1:0]         SS,
  output logic                      SCLK,
  output logic                      MOSI,
  input  logic                      MISO
);

`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int N  = 1 + ADDR_W + DATA_W + PAR;
  localparam int RW = DATA_W + PAR;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(2 * N + 1);
  localparam int SW = $clog2(SLAVES) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, ERR} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tcnt;
  logic [N-1:0]      tx_sr;
  logic [RW-1:0]     rx_sr;
  logic              write_q;
  logic              accept, busy, kill, tick, sample_edge, illegal;
  logic [N-1:0]      frame;
  logic [DATA_W-1:0] wfield;
  logic [DATA_W-1:0] rx_data;
  logic              frame_err;

  assign illegal = (req_slave >= SW'(SLAVES));

  always_comb begin
    wfield = req_write ? req_wdata : '0;
`ifdef SPI_PARITY_EN
    frame     = {~req_write, req_addr, wfield, req_write & (~^{~req_write, req_addr, wfield})};
    rx_data   = rx_sr[RW-1:1];
    frame_err = ~write_q & (rx_sr[0] != (~^rx_sr[RW-1:1]));
`else
    frame     = {~req_write, req_addr, wfield};
    rx_data   = rx_sr;
    frame_err = 1'b0;
`endif
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? ERR : SETUP;
      ERR:     state_nxt = IDLE;
      SETUP:   if (kill) state_nxt = GAP; else if (tick) state_nxt = SHIFT;
      SHIFT:   if (kill) state_nxt = GAP;
               else if (tick && tcnt == TW'(2 * N - 1)) state_nxt = HOLD;
      HOLD:    if (kill || tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Odd-numbered toggles are leading edges; CPHA picks which edge type samples.
  always_comb begin
    req_ready   = (state == IDLE);
    accept      = req_valid && (state == IDLE);
    busy        = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    kill        = abort && busy;
    tick        = (cnt == CW'(CLK_DIV - 1));
    sample_edge = (CPHA != 0) ? tcnt[0] : ~tcnt[0];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt       <= '0;
      tcnt      <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      write_q   <= 1'b0;
      SS        <= '1;
      SCLK      <= 1'(CPOL);
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE || state == ERR || tick || kill) cnt <= '0;
      else                                               cnt <= cnt + CW'(1);

      if (kill) begin
        SS        <= '1;
        SCLK      <= 1'(CPOL);
        MOSI      <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            write_q <= req_write;
            tcnt    <= '0;
            rx_sr   <= '0;
            if (illegal) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              SS <= ~(SLAVES'(1) << req_slave);
              // CPHA=0 must present the first bit before the first (sampling) edge.
              if (CPHA == 0) begin
                MOSI  <= frame[N-1];
                tx_sr <= frame << 1;
              end else begin
                tx_sr <= frame;
              end
            end
          end
          SETUP, SHIFT: if (tick) begin
            SCLK <= ~SCLK;
            tcnt <= tcnt + TW'(1);
            if (sample_edge) begin
              rx_sr <= RW'({rx_sr, MISO});
            end else begin
              MOSI  <= tx_sr[N-1];
              tx_sr <= tx_sr << 1;
            end
          end
          HOLD: if (tick) begin
            SS        <= '1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= frame_err;
            rsp_rdata <= write_q ? '0 : rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
